// File: rtl/tube_display_controller.sv
`default_nettype none
// tube_display_controller: latches CPU tube writes and scans them onto an
// 8-digit common-anode seven-segment display.  Rev 1.0
module tube_display_controller #(
  parameter int SCAN_DIVIDER = 100000
) (
  input  logic        iCpuClock,
  input  logic        iCpuReset,
  input  logic        iDoTubeWrite,
  input  logic [1:0]  iTubeAddress,
  input  logic [15:0] iTubeDataToWrite,
  output logic [7:0]  oSegment,
  output logic [7:0]  oDigitSelect,
  output logic [2:0]  oScanIndex
);

  localparam int              CNT_W    = $clog2(SCAN_DIVIDER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIVIDER - 1);

  logic [15:0]      data_low_q, data_low_d;
  logic [15:0]      data_high_q, data_high_d;
  logic [7:0]       enable_q, enable_d;
  logic [7:0]       dp_q, dp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       sel_q, sel_d;
  logic [31:0]      digits;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
      4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
      4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
      4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  default: p = 7'h0E;
    endcase
    return p;
  endfunction

  assign digits = {data_high_q, data_low_q};
  assign nibble = digits[{idx_q, 2'b00} +: 4];

  always_comb begin
    data_low_d  = data_low_q;
    data_high_d = data_high_q;
    enable_d    = enable_q;
    dp_d        = dp_q;
    if (iDoTubeWrite) begin
      case (iTubeAddress)
        2'd0:    data_low_d  = iTubeDataToWrite;
        2'd1:    data_high_d = iTubeDataToWrite;
        2'd2:    enable_d    = iTubeDataToWrite[7:0];
        default: dp_d        = iTubeDataToWrite[7:0];
      endcase
    end

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end

    // Outputs follow the current index/registers, so they trail them by one edge.
    if (enable_q[idx_q]) begin
      sel_d = ~(8'b1 << idx_q);
      seg_d = {~dp_q[idx_q], hex7(nibble)};
    end else begin
      sel_d = 8'hFF;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      data_low_q  <= 16'h0000;
      data_high_q <= 16'h0000;
      enable_q    <= 8'hFF;
      dp_q        <= 8'h00;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      seg_q       <= 8'hFF;
      sel_q       <= 8'hFF;
    end else begin
      data_low_q  <= data_low_d;
      data_high_q <= data_high_d;
      enable_q    <= enable_d;
      dp_q        <= dp_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign oSegment     = seg_q;
  assign oDigitSelect = sel_q;
  assign oScanIndex   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tube_display_controller.sv
`default_nettype none
// tb_tube_display_controller: directed self-checking bench, SCAN_DIVIDER = 4.
module tb_tube_display_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [7:0]  seg;
  logic [7:0]  sel;
  logic [2:0]  idx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] data_tbl [8] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h8E, 8'hC6, 8'h83, 8'h88};

  tube_display_controller #(.SCAN_DIVIDER(4)) dut (
    .iCpuClock        (clk),
    .iCpuReset        (rst_n),
    .iDoTubeWrite     (we),
    .iTubeAddress     (addr),
    .iTubeDataToWrite (wdata),
    .oSegment         (seg),
    .oDigitSelect     (sel),
    .oScanIndex       (idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One rising edge passes between consecutive falling edges.
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  function automatic logic [7:0] sel_of(input int d);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << d);
  endfunction

  function automatic int out_digit();
    return ((cyc - 1) / 4) % 8;
  endfunction

  initial begin
    int d;
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 8'hFF);
    check("rst_sel", sel, 8'hFF);
    check("rst_idx", idx, 3'd0);
    rst_n = 1'b1;
    cyc   = 0;

    for (int i = 0; i < 36; i++) begin
      tick();
      d = out_digit();
      check("scan_idx", idx, 32'((cyc / 4) % 8));
      check("scan_sel", sel, sel_of(d));
      check("scan_seg", seg, 8'hC0);
    end

    wr(2'd0, 16'h1234);
    wr(2'd1, 16'hABCF);
    for (int i = 0; i < 32; i++) begin
      tick();
      d = out_digit();
      check("data_seg", seg, data_tbl[d]);
      check("data_sel", sel, sel_of(d));
    end

    wr(2'd2, 16'hFF05);
    wr(2'd3, 16'h0004);
    for (int i = 0; i < 32; i++) begin
      tick();
      d = out_digit();
      if (d == 0) begin
        check("mask_seg0", seg, 8'h99);
        check("mask_sel0", sel, 8'hFE);
      end else if (d == 2) begin
        check("mask_seg2_dp", seg, 8'h24);
        check("mask_sel2", sel, 8'hFB);
      end else begin
        check("mask_seg_off", seg, 8'hFF);
        check("mask_sel_off", sel, 8'hFF);
      end
    end

    wr(2'd2, 16'h00FF);
    wr(2'd3, 16'h0000);
    for (int i = 0; i < 40 && ((cyc + 1) % 32) != 0; i++) tick();
    wr(2'd0, 16'h000F);
    check("edge_idx", idx, 3'd0);
    check("edge_sel7", sel, 8'h7F);
    check("edge_seg7", seg, 8'h88);
    tick();
    check("edge_sel0", sel, 8'hFE);
    check("edge_seg0", seg, 8'h8E);

    wr(2'd0, 16'h1111);
    wr(2'd0, 16'h2222);
    tick();
    for (int i = 0; i < 40 && out_digit() != 0; i++) tick();
    check("b2b_sel0", sel, 8'hFE);
    check("b2b_seg0", seg, 8'hA4);
    repeat (4) tick();
    check("b2b_sel1", sel, 8'hFD);
    check("b2b_seg1", seg, 8'hA4);

    repeat (6) tick();
    check("pre_rst_idx", idx, 32'((cyc / 4) % 8));
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", seg, 8'hFF);
    check("arst_sel", sel, 8'hFF);
    check("arst_idx", idx, 3'd0);
    we    = 1'b1;
    addr  = 2'd0;
    wdata = 16'h0005;
    @(negedge clk);
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    cyc   = 0;
    tick();
    check("rel_sel", sel, 8'hFE);
    check("rel_seg", seg, 8'hC0);
    check("rel_idx", idx, 3'd0);
    repeat (3) tick();
    check("rel_idx_hold", idx, 3'd1);
    check("rel_seg_hold", seg, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tube_display_controller.md
Name: tube_display_controller

Overview:
- Downstream consumer of the CPU's tube-write port (iDoTubeWrite / iTubeAddress / iTubeDataToWrite).
- Latches CPU-written hex data and per-digit enable/decimal-point masks into a small register bank.
- Time-multiplexes the stored values onto an 8-digit, common-anode seven-segment display: a scan counter advances the active digit and drives registered, active-low segment and digit-select lines.

Parameters:
SCAN_DIVIDER, 100000, clock cycles each digit stays selected; legal range >= 2.

Ports:
iCpuClock  input  1  CPU clock; all state on rising edge.
iCpuReset  input  1  asynchronous, active-low reset.
iDoTubeWrite  input  1  write strobe from CPU, one cycle per store.
iTubeAddress  input  2  register select for the write.
iTubeDataToWrite  input  16  write data.
oSegment  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
oDigitSelect  output  8  active-low digit enables; bit n = digit n (digit 0 rightmost).
oScanIndex  output  3  currently scanned digit, for debug/verification.

Behaviour:
Register map, written on a rising edge with iDoTubeWrite=1:
- Addr 0: dataLow[15:0]. Digits 3..0, 4 bits each; digit 0 = bits [3:0].
- Addr 1: dataHigh[15:0]. Digits 7..4; digit 4 = bits [3:0].
- Addr 2: enableMask[7:0] <= data[7:0]. Bits [15:8] ignored. Disabled digit = blank.
- Addr 3: dpMask[7:0] <= data[7:0]. Bits [15:8] ignored. 1 = decimal point lit.
- No readback path. Back-to-back writes on consecutive cycles are all accepted.

Reset (asynchronous, iCpuReset=0):
- dataLow = dataHigh = 0, enableMask = 8'hFF, dpMask = 8'h00.
- Scan counter = 0, oScanIndex = 0.
- oDigitSelect = 8'hFF, oSegment = 8'hFF (all dark).
- Writes are ignored while reset is low.
- Reset asserted mid-scan returns everything to the reset values immediately. After release, scanning restarts at digit 0 with counter 0.

Scan:
- The counter increments every cycle.
- When counter == SCAN_DIVIDER-1: counter <= 0 and oScanIndex <= oScanIndex+1, wrapping 7 -> 0.
- Each digit is therefore held for exactly SCAN_DIVIDER cycles; a full frame is 8*SCAN_DIVIDER cycles.

Outputs (registered, computed every cycle from the current oScanIndex and current register contents):
- oDigitSelect <= enableMask[idx] ? ~(8'b1 << idx) : 8'hFF.
- oSegment <= enableMask[idx] ? {~dpMask[idx], hex7(nibble[idx])} : 8'hFF.
- Output latency is one cycle behind the index and the register state. A write at edge k is visible on the outputs at edge k+1 if the written digit is currently scanned.
- A write on the same edge as an index advance: the new index and the new data both appear at the next edge.

hex7 patterns, active-low {g..a}:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Examples with dp off (full 8-bit oSegment): '0' -> 8'hC0, 'F' -> 8'h8E.

Test Plan:
- Reset: hold iCpuReset=0 mid-scan -> outputs 8'hFF/8'hFF and oScanIndex=0 asynchronously. Release -> first digit select 8'hFE appears one cycle later.
- Scan timing, SCAN_DIVIDER=4, no writes -> oScanIndex steps every 4 cycles, 0..7 then back to 0. oDigitSelect walks FE, FD, FB, ..., 7F. oSegment=8'hC0 throughout.
- Data, SCAN_DIVIDER=4: write addr0=16'h1234 and addr1=16'hABCF -> segment sequence over digits 0..7 is 99, B0, A4, F9, 8E, C6, 83, 88.
- Masks: write addr2=16'hFF05 and addr3=16'h0004 -> digits 1, 3..7 show oDigitSelect=FF and oSegment=FF. Digit 2 shows dp cleared (bit7=0). Upper data bits are ignored.
- Timing edge: write addr0=16'h000F on the same edge oScanIndex changes to 0 -> next edge gives oDigitSelect=FE, oSegment=8E. The write is not lost.
- Back-to-back: consecutive-cycle writes to addr0 = 0x1111 then 0x2222 -> final stored value 0x2222, digit 0 shows A4.
